// File: rtl/harness_io_frontend.sv
// I/O front end: sequences core reset from PLL lock flags, synchronises and deglitches
// input pins, registers output data/enable pairs and drives one registered debug probe.
module harness_io_frontend #(
    parameter int CHANNELS    = 4,
    parameter int LOCK_INPUTS = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int RESET_HOLD  = 16,
    parameter int PROBE_W     = $clog2(2*CHANNELS+2)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LOCK_INPUTS-1:0] locked,
    input  logic [CHANNELS-1:0]    in_pins,
    input  logic [CHANNELS-1:0]    out_data,
    input  logic [CHANNELS-1:0]    out_en,
    output logic                   core_reset,
    output logic [CHANNELS-1:0]    in_clean,
    output logic [CHANNELS-1:0]    in_edge,
    output logic [CHANNELS-1:0]    pin_out,
    output logic [CHANNELS-1:0]    pin_oe,
    input  logic [PROBE_W-1:0]     probe_sel,
    output logic                   probe
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } state_t;

    // ---------------- lock synchroniser ----------------
    logic [LOCK_INPUTS-1:0] lock_sync_reg [SYNC_STAGES];
    logic                   all_locked;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                lock_sync_reg[s] <= '0;
            end
        end else begin
            lock_sync_reg[0] <= locked;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                lock_sync_reg[s] <= lock_sync_reg[s-1];
            end
        end
    end

    assign all_locked = &lock_sync_reg[SYNC_STAGES-1];

    // ---------------- reset sequencer FSM ----------------
    state_t              state_reg, state_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= HOLD;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Lock loss is checked before the terminal count so a drop always wins.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = '0;
        case (state_reg)
            HOLD: begin
                if (all_locked) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (!all_locked) begin
                    state_next = HOLD;
                end else if (hold_cnt_reg == HOLD_W'(RESET_HOLD-1)) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (!all_locked) begin
                    state_next = HOLD;
                end
            end
            default: state_next = HOLD;
        endcase
    end

    always_comb begin
        core_reset = (state_reg != RUN);
    end

    // ---------------- input synchroniser and filter ----------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   synced;
            logic                   clean_reg;
            logic                   edge_reg;
            logic [FILT_W-1:0]      filt_cnt_reg;

            assign synced = sync_reg[SYNC_STAGES-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_reg     <= '0;
                    clean_reg    <= 1'b0;
                    edge_reg     <= 1'b0;
                    filt_cnt_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_pins[gi]};
                    edge_reg <= 1'b0;
                    // Counter tracks consecutive disagreeing samples; any agreement restarts it.
                    if (synced != clean_reg) begin
                        if (filt_cnt_reg == FILT_W'(FILTER_LEN-1)) begin
                            clean_reg    <= synced;
                            edge_reg     <= 1'b1;
                            filt_cnt_reg <= '0;
                        end else begin
                            filt_cnt_reg <= filt_cnt_reg + 1'b1;
                        end
                    end else begin
                        filt_cnt_reg <= '0;
                    end
                end
            end

            assign in_clean[gi] = clean_reg;
            assign in_edge[gi]  = edge_reg;
        end
    endgenerate

    // ---------------- output registers and probe ----------------
    logic [CHANNELS-1:0] pin_out_reg;
    logic [CHANNELS-1:0] pin_oe_reg;
    logic                probe_reg;
    logic                probe_next;

    always_comb begin
        probe_next = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (probe_sel == PROBE_W'(i)) begin
                probe_next = in_clean[i];
            end
            if (probe_sel == PROBE_W'(CHANNELS + i)) begin
                probe_next = pin_out_reg[i];
            end
        end
        if (probe_sel == PROBE_W'(2*CHANNELS)) begin
            probe_next = core_reset;
        end
        if (probe_sel == PROBE_W'(2*CHANNELS + 1)) begin
            probe_next = |in_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_out_reg <= '0;
            pin_oe_reg  <= '0;
            probe_reg   <= 1'b0;
        end else begin
            pin_out_reg <= out_data;
            pin_oe_reg  <= out_en & {CHANNELS{~core_reset}};
            probe_reg   <= probe_next;
        end
    end

    assign pin_out = pin_out_reg;
    assign pin_oe  = pin_oe_reg;
    assign probe   = probe_reg;

endmodule
